vmerge_feed_sched: RTL

Refill scheduler for the virtual merge sorter tree. It watches the tree's per-way empty bitmap and picks empty, non-exhausted ways in round-robin order. For each pick it issues a block read request to the memory side, then forwards the returned block into the tree's `din/dinen/din_idx` inputs. It sits between the external memory/DMA port and the tree, tracks per-way run progress and outstanding requests, and reports completion once every run has been fully fed.

---
 rtl/vmerge_feed_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vmerge_feed_sched.sv
// Refill scheduler for the virtual merge sorter tree: picks empty, non-exhausted ways
// in round-robin order, issues block reads and forwards returned blocks into the tree.
module vmerge_feed_sched #(
    parameter int W_LOG   = 10,
    parameter int P_LOG   = 3,
    parameter int DATW    = 64,
    parameter int R_LOG   = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [(1<<W_LOG)-1:0]         EMP,
    output logic                          REQ_VALID,
    input  logic                          REQ_READY,
    output logic [W_LOG+R_LOG-1:0]        REQ_ADDR,
    output logic [W_LOG-1:0]              REQ_IDX,
    input  logic                          RSP_VALID,
    input  logic [W_LOG-1:0]              RSP_IDX,
    input  logic [(DATW<<P_LOG)-1:0]      RSP_DAT,
    output logic [(DATW<<P_LOG)-1:0]      TREE_DIN,
    output logic                          TREE_DINEN,
    output logic [W_LOG-1:0]              TREE_IDX,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          ERR
);
    localparam int NW    = 1 << W_LOG;
    localparam int BW    = DATW << P_LOG;
    localparam int TOT_W = W_LOG + R_LOG + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [R_LOG:0]    CNT_FULL = {1'b1, {R_LOG{1'b0}}};
    localparam logic [TOT_W-1:0]  TOT_FULL = {1'b1, {(W_LOG+R_LOG){1'b0}}};
    localparam logic [7:0]        OUT_MAX  = MAX_OUT[7:0];
    localparam logic [NW-1:0]     ONE_HOT0 = {{(NW-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [R_LOG:0]         r_cnt [NW];
    logic [NW-1:0]          r_pend;
    logic [NW-1:0]          r_dlv;
    logic [TOT_W-1:0]       r_total;
    logic [7:0]             r_out;
    logic [W_LOG-1:0]       r_rr;
    logic                   r_req_valid;
    logic [W_LOG+R_LOG-1:0] r_req_addr;
    logic [W_LOG-1:0]       r_req_idx;
    logic [BW-1:0]          r_tree_din;
    logic                   r_tree_dinen;
    logic [W_LOG-1:0]       r_tree_idx;
    logic                   r_err;

    logic [NW-1:0]          w_elig;
    logic                   w_found;
    logic [W_LOG-1:0]       w_win;
    logic [W_LOG-1:0]       w_cand;
    logic [NW-1:0]          w_win_oh;
    logic [NW-1:0]          w_rsp_oh;
    logic [NW-1:0]          w_release;
    logic                   w_load;
    logic                   w_rsp;
    logic                   w_rsp_err;
    logic                   w_out_dec;
    logic                   w_start;

    always_comb begin
        for (int i = 0; i < NW; i++) begin
            w_elig[i] = EMP[i] & ~r_pend[i] & (r_cnt[i] != CNT_FULL);
        end
    end

    // Rotating priority encoder: first eligible way at or after r_rr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NW; k++) begin
            w_cand = r_rr + k[W_LOG-1:0];
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_oh  = ONE_HOT0 << w_win;
    assign w_rsp_oh  = ONE_HOT0 << RSP_IDX;
    assign w_release = r_dlv & ~EMP;
    assign w_start   = START && (r_state == S_IDLE || r_state == S_DONE);
    assign w_load    = (r_state == S_RUN) && (!r_req_valid || REQ_READY) && w_found && (r_out < OUT_MAX);
    // Responses arriving while idle belong to an aborted pass and are dropped silently.
    assign w_rsp     = RSP_VALID && (r_state != S_IDLE);
    assign w_rsp_err = w_rsp && (!r_pend[RSP_IDX] || r_dlv[RSP_IDX] || r_out == 8'd0);
    assign w_out_dec = w_rsp && (r_out != 8'd0);

    always_ff @(posedge CLK) begin
        if (RST || w_start) begin
            r_state     <= RST ? S_IDLE : S_RUN;
            for (int i = 0; i < NW; i++) begin
                r_cnt[i] <= '0;
            end
            r_pend       <= '0;
            r_dlv        <= '0;
            r_total      <= '0;
            r_out        <= '0;
            r_rr         <= '0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= '0;
            r_req_idx    <= '0;
            r_tree_din   <= '0;
            r_tree_dinen <= 1'b0;
            r_tree_idx   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == S_RUN && r_total == TOT_FULL) begin
                r_state <= S_DRAIN;
            end else if (r_state == S_DRAIN && r_out == 8'd0 && !r_req_valid) begin
                r_state <= S_DONE;
            end

            if (w_load) begin
                r_req_valid     <= 1'b1;
                r_req_idx       <= w_win;
                r_req_addr      <= {w_win, r_cnt[w_win][R_LOG-1:0]};
                r_cnt[w_win]    <= r_cnt[w_win] + 1'b1;
                r_total         <= r_total + 1'b1;
                r_rr            <= w_win + 1'b1;
            end else if (REQ_READY) begin
                r_req_valid <= 1'b0;
            end

            r_pend <= (r_pend & ~w_release) | (w_load ? w_win_oh : '0);
            r_dlv  <= (r_dlv & ~w_release) | (w_rsp ? w_rsp_oh : '0);
            r_out  <= r_out + {7'd0, w_load} - {7'd0, w_out_dec};

            r_tree_dinen <= w_rsp;
            if (w_rsp) begin
                r_tree_din <= RSP_DAT;
                r_tree_idx <= RSP_IDX;
            end
            if (w_rsp_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign REQ_VALID  = r_req_valid;
    assign REQ_ADDR   = r_req_addr;
    assign REQ_IDX    = r_req_idx;
    assign TREE_DIN   = r_tree_din;
    assign TREE_DINEN = r_tree_dinen;
    assign TREE_IDX   = r_tree_idx;
    assign BUSY       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign DONE       = (r_state == S_DONE);
    assign ERR        = r_err;
endmodule
